// File: rtl/packet_packer.sv
// packet_packer
//   Packs pairs of 42-bit packets into 128-bit queue words. The first packet
//   of a pair goes to data_out[41:0] and the second to data_out[105:64]. All
//   other bits are zero. A flush while half a word is held completes the
//   word with PAD_PKT.
//
// Ports
//   clk, rst       : clock and synchronous active-high reset
//   in_valid/ready : upstream packet handshake (accept = in_valid && in_ready)
//   in_data        : upstream packet
//   flush          : level request to emit a held half word
//   write_en       : queue word valid
//   data_out       : queue word
//   waitrequest    : queue cannot accept when high
//   idle           : no packet held
//   word_count     : words written (wraps at 2^16)
//   pad_count      : padded words written (wraps at 2^16)
//
// Handshake: a packet moves on any cycle with in_valid && in_ready. A word
// moves on any cycle with write_en && !waitrequest. Until that transfer,
// write_en and data_out hold steady.
module packet_packer #(
    parameter int                    Q_DATA_WIDTH = 128,
    parameter int                    PKT_WIDTH    = 42,
    parameter logic [PKT_WIDTH-1:0]  PAD_PKT      = 42'h3FF_FFFF_FFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [PKT_WIDTH-1:0]    in_data,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    write_en,
    output logic [Q_DATA_WIDTH-1:0] data_out,
    input  logic                    waitrequest,
    output logic                    idle,
    output logic [15:0]             word_count,
    output logic [15:0]             pad_count
);

    localparam int HALF_W = Q_DATA_WIDTH / 2;
    localparam int ZERO_W = HALF_W - PKT_WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PKT_WIDTH-1:0] slot0_q;
    logic [PKT_WIDTH-1:0] slot1_q;
    logic                 padded_q;
    logic [15:0]          word_cnt_q;
    logic [15:0]          pad_cnt_q;
    logic                 accept;
    logic                 xfer;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_EMPTY;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (accept) state_nxt = S_HALF;
            // An accept takes precedence over flush in HALF.
            S_HALF:  if (accept || flush) state_nxt = S_FULL;
            // Back-to-back: a transfer and a new packet together refill slot 0.
            S_FULL:  if (xfer) state_nxt = accept ? S_HALF : S_EMPTY;
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Outputs. Reset masks both handshakes so that a held word is dropped
    // and a packet offered during reset is not taken.
    always_comb begin
        idle     = (state == S_EMPTY);
        write_en = (state == S_FULL) && !rst;
        in_ready = !rst && ((state != S_FULL) || !waitrequest);
    end

    assign accept = in_valid && in_ready;
    assign xfer   = write_en && !waitrequest;

    // Packet slots, padded flag and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q    <= '0;
            slot1_q    <= '0;
            padded_q   <= 1'b0;
            word_cnt_q <= '0;
            pad_cnt_q  <= '0;
        end else begin
            if (xfer) begin
                word_cnt_q <= word_cnt_q + 16'd1;
                if (padded_q) pad_cnt_q <= pad_cnt_q + 16'd1;
                padded_q <= 1'b0;
            end
            case (state)
                S_EMPTY: if (accept) slot0_q <= in_data;
                S_HALF: begin
                    if (accept) begin
                        slot1_q <= in_data;
                    end else if (flush) begin
                        slot1_q  <= PAD_PKT;
                        padded_q <= 1'b1;
                    end
                end
                S_FULL:  if (xfer && accept) slot0_q <= in_data;
                default: ;
            endcase
        end
    end

    assign data_out   = {{ZERO_W{1'b0}}, slot1_q, {ZERO_W{1'b0}}, slot0_q};
    assign word_count = word_cnt_q;
    assign pad_count  = pad_cnt_q;

endmodule

// File: tb/tb_packet_packer.sv
// Directed bench for packet_packer: a vector table for steady-state packing,
// throughput and flush, then hand sequences for backpressure, reset in the
// middle of a word, and word_count wrap.
module tb_packet_packer;

    localparam logic [41:0] PAD = 42'h3FF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [41:0]  in_data;
    logic         in_ready;
    logic         flush;
    logic         write_en;
    logic [127:0] data_out;
    logic         waitrequest;
    logic         idle;
    logic [15:0]  word_count;
    logic [15:0]  pad_count;

    int n_checks = 0;
    int n_pass   = 0;

    packet_packer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .flush       (flush),
        .write_en    (write_en),
        .data_out    (data_out),
        .waitrequest (waitrequest),
        .idle        (idle),
        .word_count  (word_count),
        .pad_count   (pad_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run time limit expired, got no end, need end");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         v;
        logic [41:0]  d;
        logic         f;
        logic         w;
        logic         e_rdy;
        logic         e_we;
        logic [127:0] e_do;
        logic         e_idle;
        logic [15:0]  e_wc;
        logic [15:0]  e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [127:0] word(input logic [41:0] a, input logic [41:0] b);
        return {22'h0, b, 22'h0, a};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [41:0] d, input logic f,
                                 input logic w, input logic e_rdy, input logic e_we,
                                 input logic [127:0] e_do, input logic e_idle,
                                 input logic [15:0] e_wc, input logic [15:0] e_pc);
        vec_t r;
        r.v = v; r.d = d; r.f = f; r.w = w;
        r.e_rdy = e_rdy; r.e_we = e_we; r.e_do = e_do;
        r.e_idle = e_idle; r.e_wc = e_wc; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Apply inputs at the falling edge, then sample just after.
    task automatic drive(input logic v, input logic [41:0] d, input logic f, input logic w);
        @(negedge clk);
        in_valid    = v;
        in_data     = d;
        flush       = f;
        waitrequest = w;
        #1;
    endtask

    logic [41:0] big_a;
    logic [41:0] big_b;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; waitrequest = 1'b0;
        big_a = 42'h3AB_CDEF_0123;
        big_b = 42'h155_5555_5555;

        // Reset: packets offered during reset are refused.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 42'h3FF, 1'b0, 1'b0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_write_en", write_en, 0);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_data_out", data_out, 0);
        chk("post_rst_word_count", word_count, 0);
        chk("post_rst_idle", idle, 1);

        // Table: v, d, f, w | rdy, we, data_out, idle, word_count, pad_count
        tbl.push_back(mkv(1, 42'h001, 0, 0, 1, 0, '0,                  1, 0, 0));
        tbl.push_back(mkv(1, 42'h002, 0, 0, 1, 0, '0,                  0, 0, 0));
        tbl.push_back(mkv(0, 42'h000, 0, 0, 1, 1, word(42'h1, 42'h2),  0, 0, 0));
        tbl.push_back(mkv(0, 42'h000, 0, 0, 1, 0, '0,                  1, 1, 0));
        tbl.push_back(mkv(1, 42'h010, 0, 0, 1, 0, '0,                  1, 1, 0));
        tbl.push_back(mkv(1, 42'h011, 0, 0, 1, 0, '0,                  0, 1, 0));
        tbl.push_back(mkv(1, 42'h012, 0, 0, 1, 1, word(42'h10, 42'h11), 0, 1, 0));
        tbl.push_back(mkv(1, 42'h013, 0, 0, 1, 0, '0,                  0, 2, 0));
        tbl.push_back(mkv(1, 42'h014, 0, 0, 1, 1, word(42'h12, 42'h13), 0, 2, 0));
        tbl.push_back(mkv(1, 42'h015, 0, 0, 1, 0, '0,                  0, 3, 0));
        tbl.push_back(mkv(1, 42'h016, 0, 0, 1, 1, word(42'h14, 42'h15), 0, 3, 0));
        tbl.push_back(mkv(1, 42'h017, 0, 0, 1, 0, '0,                  0, 4, 0));
        tbl.push_back(mkv(0, 42'h000, 0, 0, 1, 1, word(42'h16, 42'h17), 0, 4, 0));
        tbl.push_back(mkv(0, 42'h000, 0, 0, 1, 0, '0,                  1, 5, 0));
        // Single packet then flush held until idle.
        tbl.push_back(mkv(1, 42'h0AA, 0, 0, 1, 0, '0,                  1, 5, 0));
        tbl.push_back(mkv(0, 42'h000, 1, 0, 1, 0, '0,                  0, 5, 0));
        tbl.push_back(mkv(0, 42'h000, 1, 0, 1, 1, word(42'hAA, PAD),   0, 5, 0));
        tbl.push_back(mkv(0, 42'h000, 1, 0, 1, 0, '0,                  1, 6, 1));
        tbl.push_back(mkv(0, 42'h000, 0, 0, 1, 0, '0,                  1, 6, 1));
        // Flush alongside the second packet is ignored; wide data patterns.
        tbl.push_back(mkv(1, big_a,   0, 0, 1, 0, '0,                  1, 6, 1));
        tbl.push_back(mkv(1, big_b,   1, 0, 1, 0, '0,                  0, 6, 1));
        tbl.push_back(mkv(0, 42'h000, 0, 0, 1, 1, word(big_a, big_b),  0, 6, 1));
        tbl.push_back(mkv(0, 42'h000, 0, 0, 1, 0, '0,                  1, 7, 1));
        // waitrequest does not block input while not FULL.
        tbl.push_back(mkv(0, 42'h000, 0, 1, 1, 0, '0,                  1, 7, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].w);
            chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d_write_en", i), write_en, tbl[i].e_we);
            chk($sformatf("v%0d_idle", i), idle, tbl[i].e_idle);
            chk($sformatf("v%0d_word_count", i), word_count, tbl[i].e_wc);
            chk($sformatf("v%0d_pad_count", i), pad_count, tbl[i].e_pc);
            if (tbl[i].e_we) chk($sformatf("v%0d_data_out", i), data_out, tbl[i].e_do);
        end

        // Backpressure: word held for 5 cycles, then transfer plus accept.
        drive(1, 42'h030, 0, 0);
        drive(1, 42'h031, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 42'h032, 0, 1);
            chk("bp_write_en", write_en, 1);
            chk("bp_data_out", data_out, word(42'h30, 42'h31));
            chk("bp_in_ready", in_ready, 0);
            chk("bp_word_count", word_count, 7);
        end
        drive(1, 42'h032, 0, 0);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_write_en", write_en, 1);
        drive(1, 42'h033, 0, 0);
        chk("bp_after_write_en", write_en, 0);
        chk("bp_after_idle", idle, 0);
        chk("bp_after_word_count", word_count, 8);
        drive(0, 42'h000, 0, 0);
        chk("bp_next_data_out", data_out, word(42'h32, 42'h33));
        chk("bp_next_write_en", write_en, 1);
        drive(0, 42'h000, 0, 0);
        chk("bp_drain_idle", idle, 1);
        chk("bp_drain_word_count", word_count, 9);

        // Reset while HALF.
        drive(1, 42'h040, 0, 0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 42'h041;
        #1;
        chk("rst_half_in_ready", in_ready, 0);
        chk("rst_half_write_en", write_en, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_half_idle", idle, 1);
        chk("rst_half_in_ready_after", in_ready, 1);
        chk("rst_half_word_count", word_count, 0);
        chk("rst_half_pad_count", pad_count, 0);

        // Reset while FULL: the held word must not be presented.
        drive(1, 42'h050, 0, 0);
        drive(1, 42'h051, 0, 0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_full_write_en", write_en, 0);
        chk("rst_full_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_full_idle", idle, 1);
        chk("rst_full_write_en_after", write_en, 0);
        chk("rst_full_word_count", word_count, 0);
        drive(1, 42'h060, 0, 0);
        drive(1, 42'h061, 0, 0);
        drive(0, 42'h000, 0, 0);
        chk("fresh_write_en", write_en, 1);
        chk("fresh_data_out", data_out, word(42'h60, 42'h61));
        drive(0, 42'h000, 0, 0);
        chk("fresh_word_count", word_count, 1);
        chk("fresh_pad_count", pad_count, 0);

        // word_count wrap: start the counter at 0xFFFF, then one transfer.
        @(negedge clk);
        force dut.word_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.word_cnt_q;
        #1;
        chk("wrap_preload", word_count, 16'hFFFF);
        drive(1, 42'h070, 0, 0);
        drive(1, 42'h071, 0, 0);
        drive(0, 42'h000, 0, 0);
        chk("wrap_write_en", write_en, 1);
        chk("wrap_before", word_count, 16'hFFFF);
        drive(0, 42'h000, 0, 0);
        chk("wrap_after", word_count, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
